// File: rtl/seg7_counter_mux.sv
// ============================================================================
// seg7_counter_mux -- multi-digit BCD/hex up/down counter with a multiplexed
//                     active-high 7-segment display driver
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_counter_mux #(
  parameter int DIGITS   = 4,
  parameter int DECIMAL  = 1,
  parameter int CLK_HZ   = 12_000_000,
  parameter int COUNT_HZ = 2,
  parameter int SCAN_HZ  = 1000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [6:0]            abcdefg,
  output logic                  dp
);

  localparam int TICK_DIV_RAW = CLK_HZ / COUNT_HZ;
  localparam int SCAN_DIV_RAW = CLK_HZ / SCAN_HZ;
  localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
  localparam int SCAN_DIV     = (SCAN_DIV_RAW < 1) ? 1 : SCAN_DIV_RAW;
  localparam int TICK_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SEL_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(DIGITS - 1);
  localparam logic [3:0]        DIGIT_MAX = (DECIMAL != 0) ? 4'd9 : 4'd15;

  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [SEL_W-1:0]    scan_idx_q, scan_idx_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic                wrap_q, wrap_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [6:0]          abcdefg_q, abcdefg_d;
  logic                dp_q, dp_d;

  logic                tick;
  logic                scan_step;
  logic                carry;
  logic [3:0]          nib;
  logic [3:0]          disp_nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Count-tick prescaler: free-running, unaffected by load or enable.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Scan prescaler and digit index.
  always_comb begin
    scan_step  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_step ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_step) begin
      scan_idx_d = (scan_idx_q == SEL_LAST) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // Counter: load beats a tick; ripple carry/borrow through all digits.
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    carry   = 1'b0;
    nib     = 4'd0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        nib = load_value[i*4 +: 4];
        if ((DECIMAL != 0) && (nib > 4'd9)) begin
          nib = 4'd9;
        end
        value_d[i*4 +: 4] = nib;
      end
    end else if (tick && enable) begin
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        nib = value_q[i*4 +: 4];
        if (carry) begin
          if (up) begin
            if (nib == DIGIT_MAX) begin
              nib = 4'd0;
            end else begin
              nib   = nib + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (nib == 4'd0) begin
              nib = DIGIT_MAX;
            end else begin
              nib   = nib - 4'd1;
              carry = 1'b0;
            end
          end
        end
        value_d[i*4 +: 4] = nib;
      end
      wrap_d = carry;
    end
  end

  // Display: select and segment come from the same index so they never disagree.
  always_comb begin
    digit_sel_d = '0;
    disp_nib    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == SEL_W'(i)) begin
        digit_sel_d[i] = 1'b1;
        disp_nib       = value_q[i*4 +: 4];
      end
    end
    abcdefg_d = seg_decode(disp_nib);
    dp_d      = !enable && (scan_idx_q == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      value_q     <= '0;
      wrap_q      <= 1'b0;
      digit_sel_q <= DIGITS'(1);
      abcdefg_q   <= 7'b1111110;
      dp_q        <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      value_q     <= value_d;
      wrap_q      <= wrap_d;
      digit_sel_q <= digit_sel_d;
      abcdefg_q   <= abcdefg_d;
      dp_q        <= dp_d;
    end
  end

  assign value     = value_q;
  assign wrap      = wrap_q;
  assign digit_sel = digit_sel_q;
  assign abcdefg   = abcdefg_q;
  assign dp        = dp_q;

endmodule

`default_nettype wire
